// File: rtl/lcd_responder.sv
// lcd_responder: cycle-level stand-in for an HD44780-style character LCD.
// Accepts instruction/data transfers on the en/rs/rw/io bus and commits each
// transfer on the falling edge of en. After every accepted write it holds its
// busy flag for a fixed time, and it answers status and data reads.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   en, rs, rw      bus strobe, register select (1 = data), direction (1 = read)
//   io              bidirectional data bus, driven only while en=1 and rw=1
//   peek_addr/data  combinational view of display RAM
//   busy            internal busy flag (status bit 7)
//   ac              address counter
//   display_on      {D,C,B} from the last Display Control instruction
//   protocol_error  sticky; a write or data read was committed while busy
module lcd_responder #(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned WRITE_CYCLES = 40,
  parameter int unsigned CLEAR_CYCLES = 160
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     rs,
  input  logic                     rw,
  inout  logic [7:0]               io,
  input  logic [$clog2(DEPTH)-1:0] peek_addr,
  output logic [7:0]               peek_data,
  output logic                     busy,
  output logic [6:0]               ac,
  output logic [2:0]               display_on,
  output logic                     protocol_error
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CMAX = (CLEAR_CYCLES > WRITE_CYCLES) ? CLEAR_CYCLES : WRITE_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [6:0]    AC_MASK        = 7'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_WRITE      = CW'(WRITE_CYCLES);
  localparam logic [CW-1:0] CNT_CLEAR_TAIL = CW'(CLEAR_CYCLES - DEPTH);
  localparam logic [AW-1:0] IDX_LAST       = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [6:0]      ac_q, ac_d;
  logic            id_q, id_d;
  logic [2:0]      disp_q, disp_d;
  logic            perr_q, perr_d;
  logic            en_q, en_d;

  logic [7:0]      ddram [DEPTH];

  logic            commit;
  logic            busy_int;
  logic            status_rd;
  logic [6:0]      ac_step;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [7:0]      mem_wdata;
  logic [7:0]      rd_data;

  assign commit    = en_q & ~en;
  assign busy_int  = (state_q != ST_IDLE);
  assign status_rd = ~rs & rw;

  // Address counter advance for data accesses, wrapping inside the RAM.
  always_comb begin
    if (id_q) ac_step = (ac_q + 7'd1) & AC_MASK;
    else      ac_step = (ac_q - 7'd1) & AC_MASK;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ac_d      = ac_q;
    id_d      = id_q;
    disp_d    = disp_q;
    en_d      = en;
    mem_we    = 1'b0;
    mem_addr  = ac_q[AW-1:0];
    mem_wdata = io;

    // Only a status read is legal while busy; anything else is dropped and flagged.
    perr_d = perr_q | (commit & busy_int & ~status_rd);

    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          if (rs) begin
            if (!rw) begin
              mem_we  = 1'b1;
              state_d = ST_EXEC;
              cnt_d   = CNT_WRITE;
            end
            ac_d = ac_step;
          end else if (!rw) begin
            // Instructions decode on their highest set bit.
            state_d = ST_EXEC;
            cnt_d   = CNT_WRITE;
            casez (io)
              8'b1???_????: ac_d = io[6:0] & AC_MASK;
              8'b0000_1???: disp_d = io[2:0];
              8'b0000_01??: id_d = io[1];
              8'b0000_001?: ac_d = '0;
              8'b0000_0001: begin
                ac_d    = '0;
                id_d    = 1'b1;
                idx_d   = '0;
                state_d = ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end

      ST_EXEC: begin
        if (cnt_q == CW'(1)) state_d = ST_IDLE;
        else                 cnt_d   = cnt_q - CW'(1);
      end

      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = idx_q;
        mem_wdata = 8'h20;
        // The sweep occupies DEPTH cycles; EXEC supplies the rest of the clear time.
        if (idx_q == IDX_LAST) begin
          state_d = ST_EXEC;
          cnt_d   = CNT_CLEAR_TAIL;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      idx_q   <= '0;
      ac_q    <= '0;
      id_q    <= 1'b1;
      disp_q  <= '0;
      perr_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ac_q    <= ac_d;
      id_q    <= id_d;
      disp_q  <= disp_d;
      perr_q  <= perr_d;
      en_q    <= en_d;
    end
  end

  // RAM has no reset; the CLEAR sweep that follows reset initialises it.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) ddram[mem_addr] <= mem_wdata;
  end

  assign rd_data = rs ? ddram[ac_q[AW-1:0]] : {busy_int, ac_q};
  assign io      = (en && rw && !rst) ? rd_data : 'z;

  assign peek_data      = ddram[peek_addr];
  assign busy           = busy_int;
  assign ac             = ac_q;
  assign display_on     = disp_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_lcd_responder.sv
module tb_lcd_responder;

  localparam int D = 32;
  localparam int W = 40;
  localparam int C = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rs;
  logic       rw;
  logic [7:0] tb_io;
  logic       tb_oe;
  wire  [7:0] io;
  logic [4:0] peek_addr;
  logic [7:0] peek_data;
  logic       busy;
  logic [6:0] ac;
  logic [2:0] display_on;
  logic       protocol_error;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign io = tb_oe ? tb_io : 8'bz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_responder #(
    .DEPTH(D),
    .WRITE_CYCLES(W),
    .CLEAR_CYCLES(C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .rs(rs),
    .rw(rw),
    .io(io),
    .peek_addr(peek_addr),
    .peek_data(peek_data),
    .busy(busy),
    .ac(ac),
    .display_on(display_on),
    .protocol_error(protocol_error)
  );

  // ---------------- reference model ----------------
  logic [7:0]  m_ram [D];
  int          m_ac;
  bit          m_inc;
  logic [2:0]  m_disp;
  bit          m_perr;
  int unsigned m_busy_end;    // first post-edge cycle index at which busy reads 0
  int unsigned m_clear_done;  // from this cycle index on, RAM holds the cleared image

  task automatic m_reset(input int unsigned r);
    for (int i = 0; i < D; i++) m_ram[i] = 8'h20;
    m_ac         = 0;
    m_inc        = 1;
    m_disp       = 3'd0;
    m_perr       = 0;
    m_busy_end   = r + C;
    m_clear_done = r + D;
  endtask

  task automatic m_step();
    if (m_inc) m_ac = (m_ac + 1) % D;
    else       m_ac = (m_ac + D - 1) % D;
  endtask

  // c is the cycle index sampled just after the committing edge.
  task automatic m_commit(input int unsigned c, input bit r_s, input bit r_w, input logic [7:0] d);
    if (c <= m_busy_end) begin
      if (r_s || !r_w) m_perr = 1;
      return;
    end
    if (r_s) begin
      if (!r_w) begin
        m_ram[m_ac] = d;
        m_busy_end  = c + W;
      end
      m_step();
    end else if (!r_w) begin
      m_busy_end = c + W;
      if (d >= 8'h80)      m_ac = (int'(d) - 128) % D;
      else if (d >= 8'h10) begin end
      else if (d >= 8'h08) m_disp = d[2:0];
      else if (d >= 8'h04) m_inc = d[1];
      else if (d >= 8'h02) m_ac = 0;
      else if (d == 8'h01) begin
        for (int i = 0; i < D; i++) m_ram[i] = 8'h20;
        m_ac         = 0;
        m_inc        = 1;
        m_busy_end   = c + C;
        m_clear_done = c + D;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Called just after a posedge. en high for one cycle, commit on the next edge.
  task automatic xfer(input bit r_s, input bit r_w, input logic [7:0] d,
                      output logic [7:0] rd, output int unsigned c);
    rs    = r_s;
    rw    = r_w;
    tb_io = d;
    tb_oe = !r_w;
    en    = 1'b1;
    @(posedge clk); #1;
    rd = io;
    en = 1'b0;
    @(posedge clk); #1;
    c     = cyc;
    tb_oe = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_until(input int unsigned x);
    while (cyc < x) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    bit         rs;
    bit         rw;
    logic [7:0] din;
    bit         chk_io;
    logic [7:0] exp_io;
    logic [6:0] exp_ac;
    logic [4:0] paddr;
    logic [7:0] exp_peek;
    logic [2:0] exp_disp;
    int         exp_busy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd;
    logic [7:0]  exp_rd;
    int unsigned c, c0, c1, r;
    int          n;
    int          ac_before;
    bit          busy_before;

    rst = 1'b1; en = 1'b0; rs = 1'b0; rw = 1'b0;
    tb_io = 8'h00; tb_oe = 1'b0; peek_addr = '0;

    // ---- reset and init timing ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_ac", ac, 0);
    chk("rst_disp", display_on, 0);
    chk("rst_perr", protocol_error, 0);
    rst = 1'b0; en = 1'b1; rw = 1'b1; rs = 1'b0;
    #1;
    n = 0;
    while (n < 1000 && io === 8'h80) begin
      n++;
      @(posedge clk); #1;
    end
    chk("init_busy_len", n, C);
    chk("init_status_idle", io, 8'h00);
    chk("init_busy_out", busy, 0);
    en = 1'b0;
    @(posedge clk); #1;
    chk("init_status_no_perr", protocol_error, 0);
    for (int i = 0; i < D; i++) begin
      peek_addr = 5'(i);
      #1;
      chk($sformatf("init_peek%0d", i), peek_data, 8'h20);
    end
    @(posedge clk); #1;

    // ---- table-driven transfers, each followed by a full busy window ----
    tbl.push_back('{0,0,8'h85,0,8'h00, 5, 5,8'h20,0,W});
    tbl.push_back('{1,0,8'h41,0,8'h00, 6, 5,8'h41,0,W});
    tbl.push_back('{1,0,8'h42,0,8'h00, 7, 6,8'h42,0,W});
    tbl.push_back('{0,0,8'h04,0,8'h00, 7, 7,8'h20,0,W});
    tbl.push_back('{0,0,8'h80,0,8'h00, 0, 0,8'h20,0,W});
    tbl.push_back('{1,0,8'h55,0,8'h00,31, 0,8'h55,0,W});
    tbl.push_back('{1,0,8'h66,0,8'h00,30,31,8'h66,0,W});
    tbl.push_back('{0,0,8'h06,0,8'h00,30,30,8'h20,0,W});
    tbl.push_back('{0,0,8'h83,0,8'h00, 3, 3,8'h20,0,W});
    tbl.push_back('{1,0,8'h41,0,8'h00, 4, 3,8'h41,0,W});
    tbl.push_back('{0,0,8'h83,0,8'h00, 3, 4,8'h20,0,W});
    tbl.push_back('{1,1,8'h00,1,8'h41, 4, 3,8'h41,0,0});
    tbl.push_back('{0,1,8'h00,1,8'h04, 4, 3,8'h41,0,0});
    tbl.push_back('{0,0,8'h0F,0,8'h00, 4, 5,8'h41,7,W});
    tbl.push_back('{0,0,8'hA5,0,8'h00, 5, 6,8'h42,7,W});
    tbl.push_back('{0,0,8'h0A,0,8'h00, 5, 0,8'h55,2,W});
    tbl.push_back('{0,0,8'h03,0,8'h00, 0,31,8'h66,2,W});
    tbl.push_back('{0,0,8'h3F,0,8'h00, 0, 7,8'h20,2,W});
    tbl.push_back('{0,0,8'h00,0,8'h00, 0, 0,8'h55,2,W});
    tbl.push_back('{0,0,8'h14,0,8'h00, 0, 0,8'h55,2,W});
    tbl.push_back('{0,0,8'h5A,0,8'h00, 0, 0,8'h55,2,W});
    tbl.push_back('{0,0,8'h04,0,8'h00, 0, 0,8'h55,2,W});
    tbl.push_back('{0,0,8'h01,0,8'h00, 0, 5,8'h20,2,C});
    tbl.push_back('{1,0,8'h77,0,8'h00, 1, 0,8'h77,2,W});

    foreach (tbl[i]) begin
      peek_addr = tbl[i].paddr;
      xfer(tbl[i].rs, tbl[i].rw, tbl[i].din, rd, c);
      if (tbl[i].chk_io) chk($sformatf("vec%0d_io", i), rd, tbl[i].exp_io);
      chk($sformatf("vec%0d_ac", i), ac, tbl[i].exp_ac);
      chk($sformatf("vec%0d_disp", i), display_on, tbl[i].exp_disp);
      chk($sformatf("vec%0d_perr", i), protocol_error, 0);
      count_busy(n);
      chk($sformatf("vec%0d_busy_len", i), n, tbl[i].exp_busy);
      chk($sformatf("vec%0d_peek", i), peek_data, tbl[i].exp_peek);
    end

    // ---- busy-window boundaries and protocol error ----
    xfer(1, 0, 8'h78, rd, c0);
    chk("pe_ac_after_write", ac, 2);
    xfer(0, 1, 8'h00, rd, c);
    chk("pe_status_busy_io", rd, 8'h82);
    chk("pe_status_no_perr", protocol_error, 0);
    peek_addr = 5'd2;
    wait_until(c0 + W - 2);
    xfer(1, 0, 8'h33, rd, c);           // commits on the last busy edge
    chk("pe_edge_ac", ac, 2);
    chk("pe_edge_peek", peek_data, 8'h20);
    chk("pe_edge_perr", protocol_error, 1);
    chk("pe_edge_idle_after", busy, 0);
    xfer(1, 0, 8'h44, rd, c1);
    chk("pe_write_ok_ac", ac, 3);
    chk("pe_write_ok_peek", peek_data, 8'h44);
    peek_addr = 5'd3;
    wait_until(c1 + W - 1);
    xfer(1, 0, 8'h45, rd, c);           // first edge after busy drops
    chk("pe_first_idle_ac", ac, 4);
    chk("pe_first_idle_peek", peek_data, 8'h45);
    chk("pe_first_idle_busy", busy, 1);
    xfer(1, 1, 8'h00, rd, c);
    chk("pe_busy_read_ac", ac, 4);
    xfer(0, 0, 8'h89, rd, c);
    chk("pe_busy_instr_ac", ac, 4);
    count_busy(n);
    chk("pe_busy_tail", n, W - 4);
    chk("pe_sticky", protocol_error, 1);

    // ---- fill RAM, clear, reset in the middle of the clear ----
    xfer(0, 0, 8'h80, rd, c);
    count_busy(n);
    for (int i = 0; i < D; i++) begin
      xfer(1, 0, 8'(8'h30 + i), rd, c);
      count_busy(n);
      chk($sformatf("fill%0d_busy_len", i), n, W);
    end
    peek_addr = 5'd5;
    xfer(0, 0, 8'h01, rd, c);
    chk("clr_byte5_j0", peek_data, 8'h35);
    wait_until(c + 5);
    chk("clr_byte5_j5", peek_data, 8'h35);
    wait_until(c + 6);
    chk("clr_byte5_j6", peek_data, 8'h20);
    wait_until(c + 10);
    rst = 1'b1;
    @(posedge clk); #1;
    r = cyc;
    rst = 1'b0;
    chk("clr_rst_perr", protocol_error, 0);
    chk("clr_rst_disp", display_on, 0);
    chk("clr_rst_ac", ac, 0);
    chk("clr_rst_busy", busy, 1);
    peek_addr = 5'd20;
    #1;
    chk("clr_byte20_pending", peek_data, 8'h44);
    wait_until(r + 20);
    chk("clr_byte20_j20", peek_data, 8'h44);
    wait_until(r + 21);
    chk("clr_byte20_j21", peek_data, 8'h20);
    count_busy(n);
    chk("clr_rst_busy_tail", n, C - 21);
    for (int i = 0; i < D; i++) begin
      peek_addr = 5'(i);
      #1;
      chk($sformatf("clr_peek%0d", i), peek_data, 8'h20);
    end

    // ---- randomized traffic against the model ----
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset(cyc);
    for (int k = 0; k < 250; k++) begin
      int          op;
      int          w;
      bit          r_s;
      bit          r_w;
      logic [7:0]  d;
      logic [7:0]  exp_data;
      w = $urandom_range(0, 9);
      if (w <= 5)                         wait_until(m_busy_end - 1);
      else if (w == 6 && m_busy_end >= 2) wait_until(m_busy_end - 2);
      else if (w == 7) repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      op = $urandom_range(0, 9);
      d  = 8'($urandom);
      if (op <= 3)      begin r_s = 1; r_w = 0; end
      else if (op == 4) begin r_s = 1; r_w = 1; end
      else if (op == 5) begin r_s = 0; r_w = 1; end
      else begin
        r_s = 0; r_w = 0;
        case ($urandom_range(0, 7))
          0: d = 8'h80 | 8'($urandom_range(0, 127));
          1: d = 8'h04 | 8'($urandom_range(0, 3));
          2: d = 8'h08 | 8'($urandom_range(0, 7));
          3: d = 8'h02 | 8'($urandom_range(0, 1));
          4: d = 8'($urandom_range(16, 127));
          5: d = 8'h00;
          6: d = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h06;
          default: ;
        endcase
      end
      ac_before = m_ac;
      exp_data  = m_ram[m_ac];
      xfer(r_s, r_w, d, rd, c);
      busy_before = ((c - 1) < m_busy_end);
      if (r_w && !r_s) begin
        exp_rd = {busy_before, 7'(ac_before)};
        chk($sformatf("rnd%0d_status", k), rd, exp_rd);
      end
      if (r_w && r_s && (c - 1) >= m_clear_done)
        chk($sformatf("rnd%0d_data", k), rd, exp_data);
      m_commit(c, r_s, r_w, d);
      chk($sformatf("rnd%0d_ac", k), ac, 7'(m_ac));
      chk($sformatf("rnd%0d_busy", k), busy, (c < m_busy_end));
      chk($sformatf("rnd%0d_disp", k), display_on, m_disp);
      chk($sformatf("rnd%0d_perr", k), protocol_error, m_perr);
    end
    wait_until(m_busy_end);
    chk("rnd_final_idle", busy, 0);
    for (int i = 0; i < D; i++) begin
      peek_addr = 5'(i);
      #1;
      chk($sformatf("rnd_peek%0d", i), peek_data, m_ram[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_responder.md
# lcd_responder

Synthesizable model of the HD44780-style character LCD that sits on the far end of the `en`/`rs`/`rw`/`io` bus. It accepts instruction and data transfers from the LCD controller, holds its busy flag for a fixed number of cycles after each accepted write, and answers status and data reads. Display RAM is exposed on a peek port. The block replaces the physical panel in simulation and on-chip loopback builds, and is the bench's scoreboard for the controller.

## Interface
- `DEPTH`, 32: DDRAM bytes (2×16 display); a power of two, ≤128.
- `WRITE_CYCLES`, 40: busy duration after any accepted non-clear write, ≥1.
- `CLEAR_CYCLES`, 160: total busy duration for Clear Display and for reset init; must be ≥ DEPTH+1.
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `en`  in  1  bus enable from the controller; a transfer commits on its falling edge.
- `rs`  in  1  0 = instruction/status, 1 = data.
- `rw`  in  1  1 = read, 0 = write.
- `io`  inout  8  bus; driven only while `en`=1 and `rw`=1, else high-Z.
- `peek_addr`  in  log2(DEPTH)  DDRAM peek address.
- `peek_data`  out  8  combinational `ddram[peek_addr]`.
- `busy`  out  1  internal busy flag, equal to status bit 7.
- `ac`  out  7  address counter.
- `display_on`  out  3  {D,C,B} from the last Display Control instruction.
- `protocol_error`  out  1  sticky; set by a write or data read committed while busy.

## Operation
- `en_q` registers `en`. A commit occurs at a posedge where `en_q`=1 and `en`=0. At that posedge `rs`, `rw`, and `io` are sampled.
- Read drive (combinational, while `en`=1 and `rw`=1):
  - `rs`=0: `io` = {busy, ac}.
  - `rs`=1: `io` = `ddram[ac]`.
- States:
  - IDLE: `busy`=0.
  - EXEC: `busy`=1, counting `cnt` down.
  - CLEAR: `busy`=1; writes 0x20 to `ddram[idx]`, one byte per cycle, idx 0..DEPTH-1.
- Commit in IDLE:
  - Write, `rs`=1: `ddram[ac]` ← io; `ac` steps by ±1 according to I/D, wrapping mod DEPTH. Go to EXEC with `cnt` = WRITE_CYCLES.
  - Read, `rs`=1: `ac` steps as for a write. State stays IDLE; no busy.
  - Read, `rs`=0: no effect.
  - Write, `rs`=0, decoded by highest set bit:
    - 0x80|a: `ac` ← a mod DEPTH.
    - 0x40–0x7F (CGRAM), 0x20–0x3F (function set), 0x10–0x1F (shift): accepted, no effect.
    - 0x08–0x0F: `display_on` ← io[2:0].
    - 0x04–0x07: I/D ← io[1] (1 = increment).
    - 0x02/0x03: `ac` ← 0.
    - 0x01: `ac` ← 0, I/D ← 1, go to CLEAR.
    - 0x00: no effect, but still busy.
  - Every instruction write except 0x01 goes to EXEC with `cnt` = WRITE_CYCLES.
- Commit while busy:
  - A status read is legal.
  - Any write or data read is ignored: no RAM, `ac`, or state change. `protocol_error` ← 1.
- CLEAR → EXEC with `cnt` = CLEAR_CYCLES − DEPTH after idx = DEPTH−1.
- EXEC → IDLE on the posedge where `cnt` = 1.
- Reset, including mid-operation:
  - While `rst`: state = CLEAR with idx = 0, `ac`=0, I/D=1, `display_on`=0, `protocol_error`=0, `en_q`=0, `io` high-Z.
  - `busy`=1 during and after reset.
  - DDRAM contents are not reset directly; CLEAR overwrites them.
  - A commit in the same cycle as `rst` is discarded.

## Timing
- Outputs are registered; `peek_data` and the `io` drive are combinational from registers.
- A non-clear write committed at edge T: `busy` = 1 from T+1 through T+WRITE_CYCLES, and 0 at T+WRITE_CYCLES+1.
- Clear committed at T, or `rst` deasserted before edge T: `busy` = 1 for exactly CLEAR_CYCLES cycles starting at T+1.
- Clear RAM timing: byte k becomes 0x20 at T+1+k. All bytes read 0x20 by T+DEPTH+1.
- Data write at T: `peek_data` reflects the new byte and `ac` the new value from T+1.
- Status read: `io` is valid in the same cycle `en` rises and tracks `busy` live while `en` stays high.
- `en` must stay high ≥1 cycle; a 0-cycle pulse is not a transfer.

## Test plan
- Reset, then poll status: `io`=0x80 for 160 cycles after `rst` falls, then 0x00. Every `peek` address reads 0x20.
- Instruction 0x80|5, wait, then data 0x41 and 0x42: `ddram[5]`=0x41, `ddram[6]`=0x42, `ac`=7. Busy lasts 40 cycles after each write.
- Entry mode 0x04 (decrement), set `ac`=0, write 0x55: `ddram[0]`=0x55 and `ac`=31 (wrap-around).
- Write data 0x33 during a busy window: `ddram[ac]` unchanged, `ac` unchanged, `protocol_error`=1 until the next `rst`.
- Set `ac`=3 holding 0x41; data read with `rs`=1, `rw`=1: `io`=0x41 while `en` is high, `ac`=4 after the fall, `busy` stays 0.
- Clear 0x01 issued after filling RAM, with `rst` pulsed 10 cycles into the clear: all RAM reaches 0x20, `busy` lasts 160 cycles from reset release, `display_on`=0.
